branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Consumer end of the branch-prediction interface. Queues each prediction issued at ID and
//  checks it in order against the actual outcome resolved in EX. On a mismatch it raises a
//  one-cycle flush with the corrected fetch PC. It returns a training update (PC, outcome) to
//  the predictor over a valid/ready handshake, and keeps saturating branch/mispredict counters.
// PARAMETERS
//  DEPTH  4   in-flight prediction queue entries (power of 2, >=2)
//  PC_W   32  PC / target width
//  CNT_W  16  statistics counter width
// PORTS
//  clk            in   1              rising-edge clock
//  rst_n          in   1              asynchronous active-low reset
//  pred_valid     in   1              ID pushes a predicted branch
//  pred_pc        in   PC_W           PC of predicted branch
//  pred_taken     in   1              predicted direction
//  pred_target    in   PC_W           predicted taken target
//  pred_ready     out  1              queue can accept (push = pred_valid & pred_ready)
//  res_valid      in   1              EX resolves oldest queued branch
//  res_taken      in   1              actual direction
//  res_target     in   PC_W           actual taken target
//  res_ready      out  1              resolution accepted (acc = res_valid & res_ready)
//  flush          out  1              registered 1-cycle mispredict pulse
//  redirect_pc    out  PC_W           corrected fetch PC, valid while flush=1
//  upd_valid      out  1              predictor training update pending
//  upd_pc         out  PC_W           PC to train
//  upd_taken      out  1              outcome to train
//  upd_ready      in   1              predictor accepts update
//  occupancy      out  $clog2(DEPTH+1) queued entries
//  branch_cnt     out  CNT_W          resolved branches (saturating)
//  mispred_cnt    out  CNT_W          mispredicts (saturating)
//  err_underflow  out  1              sticky: resolution with empty queue
// BEHAVIOUR
//  Reset (async, rst_n=0): queue empty, occupancy=0, flush=0, redirect_pc=0, upd_valid=0,
//    upd_pc=0, upd_taken=0, counters=0, err_underflow=0, state=IDLE. Mid-operation reset
//    drops all entries and any pending update immediately.
//  FSM: IDLE -> FLUSH on an accepted mispredicting resolution. FLUSH -> IDLE after one cycle.
//  pred_ready = (occupancy<DEPTH) & (state!=FLUSH). No same-cycle pop bypass: full blocks push.
//  res_ready = ~upd_valid | upd_ready. An accepted resolution pops the oldest entry.
//    Queue order is strict FIFO; pointers wrap modulo DEPTH.
//  Accepted resolution with empty queue (incl. same-cycle push into an empty queue): no pop,
//    no update, no counter change; err_underflow<=1 (cleared only by reset).
//  Mispredict: (pred_taken!=res_taken) | (pred_taken & res_taken & pred_target!=res_target).
//  Latency 1 after acceptance:
//    upd_valid<=1, upd_pc<=entry.pc, upd_taken<=res_taken.
//    branch_cnt+=1; on mispredict also mispred_cnt+=1, flush<=1,
//    redirect_pc<= res_taken ? res_target : entry.pc+4 (PC_W-bit wrap).
//  Mispredict squash: in the acceptance cycle all remaining entries are discarded and any
//    same-cycle push is dropped; occupancy=0 next cycle. During the FLUSH cycle pushes are
//    refused. Correct predictions leave younger entries intact.
//  Update handshake: upd_* hold stable while upd_valid & ~upd_ready. upd_valid clears on
//    upd_ready unless a new resolution is accepted that same cycle (back-to-back reload).
//  Simultaneous push+pop in IDLE with no mispredict: occupancy unchanged.
//  Counters saturate at all-ones; they never wrap.
// TESTING
//  1 Reset mid-run: 3 entries queued, upd_valid=1, rst_n=0 -> occupancy=0, upd_valid=0,
//    flush=0, counters=0, asynchronously.
//  2 Correct: push pc=0x100 taken tgt=0x200; resolve taken tgt=0x200 -> next cycle upd_valid=1,
//    upd_pc=0x100, upd_taken=1, flush=0, branch_cnt=1, mispred_cnt=0.
//  3 Mispredict not-taken: push pc=0x40 taken, then 0x44, 0x48; resolve not-taken -> flush=1
//    for 1 cycle, redirect_pc=0x44, occupancy=0, pred_ready=0 in flush cycle.
//  4 Target mismatch: pred tgt=0x300, res taken tgt=0x380 -> flush=1, redirect_pc=0x380.
//  5 Full/backpressure: DEPTH=4 entries pushed -> pred_ready=0; hold upd_ready=0 after one
//    resolve -> res_ready=0, upd_* stable; raise upd_ready -> second update same cycle.
//  6 Underflow: res_valid with empty queue -> err_underflow=1, branch_cnt unchanged, no upd.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of ID-stage predictions checked against EX outcomes,
// producing a one-cycle flush/redirect, a predictor training update and saturating statistics.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pred_valid,
    input  logic [PC_W-1:0]            pred_pc,
    input  logic                       pred_taken,
    input  logic [PC_W-1:0]            pred_target,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [PC_W-1:0]            res_target,
    output logic                       res_ready,
    output logic                       flush,
    output logic [PC_W-1:0]            redirect_pc,
    output logic                       upd_valid,
    output logic [PC_W-1:0]            upd_pc,
    output logic                       upd_taken,
    input  logic                       upd_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           branch_cnt,
    output logic [CNT_W-1:0]           mispred_cnt,
    output logic                       err_underflow
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_mem    [DEPTH];
    logic             taken_mem [DEPTH];
    logic [PC_W-1:0]  tgt_mem   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             upd_valid_q, upd_valid_d;
    logic             upd_taken_q, upd_taken_d;
    logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
    logic [PC_W-1:0]  redirect_q, redirect_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic             err_q, err_d;

    logic             res_acc;
    logic             pop;
    logic             push;
    logic             mispred;
    logic [PC_W-1:0]  head_pc;
    logic [PC_W-1:0]  head_tgt;
    logic             head_taken;

    assign pred_ready = (occ_q < OCC_W'(DEPTH)) && (state_q != S_FLUSH);
    assign res_ready  = !upd_valid_q || upd_ready;
    assign res_acc    = res_valid && res_ready;
    assign pop        = res_acc && (occ_q != '0);

    assign head_pc    = pc_mem[rd_ptr_q];
    assign head_tgt   = tgt_mem[rd_ptr_q];
    assign head_taken = taken_mem[rd_ptr_q];

    // Target only matters when both prediction and outcome are taken.
    assign mispred = pop && ((head_taken != res_taken) ||
                             (head_taken && res_taken && (head_tgt != res_target)));
    // A mispredict squashes the whole queue, including anything arriving this cycle.
    assign push    = pred_valid && pred_ready && !mispred;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= pred_pc;
            taken_mem[wr_ptr_q] <= pred_taken;
            tgt_mem[wr_ptr_q]   <= pred_target;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mispred) state_d = S_FLUSH;
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        occ_d         = occ_q;
        upd_valid_d   = upd_valid_q;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        redirect_d    = redirect_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        err_d         = err_q;

        if (res_acc && !pop) begin
            err_d = 1'b1;
        end

        if (mispred) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end

        // A stalled update blocks res_ready, so a pop never overwrites a pending update.
        if (pop) begin
            upd_valid_d = 1'b1;
            upd_pc_d    = head_pc;
            upd_taken_d = res_taken;
        end else if (upd_ready) begin
            upd_valid_d = 1'b0;
        end

        if (pop && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end

        if (mispred) begin
            redirect_d = res_taken ? res_target : head_pc + PC_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            occ_q         <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            occ_q         <= occ_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            redirect_q    <= redirect_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            err_q         <= err_d;
        end
    end

    assign flush         = (state_q == S_FLUSH);
    assign redirect_pc   = redirect_q;
    assign upd_valid     = upd_valid_q;
    assign upd_pc        = upd_pc_q;
    assign upd_taken     = upd_taken_q;
    assign occupancy     = occ_q;
    assign branch_cnt    = branch_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic checked every cycle against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pred_valid = 1'b0, pred_taken = 1'b0;
    logic [PC_W-1:0]  pred_pc = '0, pred_target = '0;
    logic             pred_ready;
    logic             res_valid = 1'b0, res_taken = 1'b0;
    logic [PC_W-1:0]  res_target = '0;
    logic             res_ready;
    logic             flush;
    logic [PC_W-1:0]  redirect_pc;
    logic             upd_valid, upd_taken;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_ready = 1'b0;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;
    logic             err_underflow;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .res_ready(res_ready),
        .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .occupancy(occupancy), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish, required finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] tgt;
    } ent_t;

    ent_t            mq[$];
    logic            m_flush, m_uv, m_ut, m_err;
    logic [PC_W-1:0] m_redir, m_upc;
    int              m_b, m_m;

    task automatic model_reset();
        mq.delete();
        m_flush = 1'b0; m_uv = 1'b0; m_ut = 1'b0; m_err = 1'b0;
        m_redir = '0;   m_upc = '0;  m_b = 0;     m_m = 0;
    endtask

    task automatic check_model();
        logic e_pr, e_rr;
        e_pr = (mq.size() < DEPTH) && !m_flush;
        e_rr = !m_uv || upd_ready;
        chk("m_pred_ready", 64'(pred_ready), 64'(e_pr));
        chk("m_res_ready", 64'(res_ready), 64'(e_rr));
        chk("m_flush", 64'(flush), 64'(m_flush));
        if (m_flush) chk("m_redirect_pc", 64'(redirect_pc), 64'(m_redir));
        chk("m_upd_valid", 64'(upd_valid), 64'(m_uv));
        if (m_uv) begin
            chk("m_upd_pc", 64'(upd_pc), 64'(m_upd_pc_val()));
            chk("m_upd_taken", 64'(upd_taken), 64'(m_ut));
        end
        chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
        chk("m_branch_cnt", 64'(branch_cnt), 64'(m_b));
        chk("m_mispred_cnt", 64'(mispred_cnt), 64'(m_m));
        chk("m_err_underflow", 64'(err_underflow), 64'(m_err));
    endtask

    function automatic logic [PC_W-1:0] m_upd_pc_val();
        return m_upc;
    endfunction

    // Advances the model by one clock using the currently driven inputs.
    task automatic model_advance();
        logic pr, rr, acc, push, mis, popped;
        ent_t e, ne;
        pr = (mq.size() < DEPTH) && !m_flush;
        rr = !m_uv || upd_ready;
        acc = res_valid && rr;
        push = pred_valid && pr;
        mis = 1'b0;
        popped = 1'b0;
        if (acc && mq.size() == 0) begin
            m_err = 1'b1;
        end else if (acc) begin
            e = mq.pop_front();
            popped = 1'b1;
            mis = (e.taken != res_taken) || (res_taken && (e.tgt != res_target));
            if (m_b < CMAX) m_b++;
            if (mis) begin
                if (m_m < CMAX) m_m++;
                m_redir = res_taken ? res_target : e.pc + 32'd4;
                mq.delete();
            end
        end
        if (popped) begin
            m_uv = 1'b1; m_upc = e.pc; m_ut = res_taken;
        end else if (upd_ready) begin
            m_uv = 1'b0;
        end
        m_flush = mis;
        if (push && !mis) begin
            ne.pc = pred_pc; ne.taken = pred_taken; ne.tgt = pred_target;
            mq.push_back(ne);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic pv, input logic [PC_W-1:0] ppc, input logic pt,
                         input logic [PC_W-1:0] ptg, input logic rv, input logic rt,
                         input logic [PC_W-1:0] rtg, input logic ur);
        pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
        res_valid = rv;  res_taken = rt; res_target = rtg; upd_ready = ur;
    endtask

    task automatic step();
        #1;
        check_model();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_branch_cnt", 64'(branch_cnt), 64'd0);
        chk("rst_mispred_cnt", 64'(mispred_cnt), 64'd0);
        chk("rst_err_underflow", 64'(err_underflow), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic pv; logic [PC_W-1:0] ppc; logic pt; logic [PC_W-1:0] ptg;
        logic rv; logic rt; logic [PC_W-1:0] rtg; logic ur;
        logic e_fl; logic [PC_W-1:0] e_rd; logic e_uv; logic [PC_W-1:0] e_upc; logic e_ut;
        int e_occ; int e_b; int e_m; logic e_pr;
    } vec_t;

    vec_t tbl[17];

    initial begin
        //           pv ppc           pt ptg       rv rt rtg      ur  fl rd       uv upc           ut occ b  m  pr
        tbl[0]  = '{1, 32'h100,      1, 32'h200, 0, 0, 32'h0,   1,  0, 32'h0,   0, 32'h0,        0, 1, 0, 0, 1};
        tbl[1]  = '{0, 32'h0,        0, 32'h0,   1, 1, 32'h200, 1,  0, 32'h0,   1, 32'h100,      1, 0, 1, 0, 1};
        tbl[2]  = '{1, 32'h40,       1, 32'h80,  0, 0, 32'h0,   1,  0, 32'h0,   0, 32'h100,      1, 1, 1, 0, 1};
        tbl[3]  = '{1, 32'h44,       0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h0,   0, 32'h100,      1, 2, 1, 0, 1};
        tbl[4]  = '{1, 32'h48,       0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h0,   0, 32'h100,      1, 3, 1, 0, 1};
        tbl[5]  = '{0, 32'h0,        0, 32'h0,   1, 0, 32'h0,   1,  1, 32'h44,  1, 32'h40,       0, 0, 2, 1, 0};
        tbl[6]  = '{1, 32'h50,       0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h44,  0, 32'h40,       0, 0, 2, 1, 1};
        tbl[7]  = '{1, 32'h60,       1, 32'h300, 0, 0, 32'h0,   1,  0, 32'h44,  0, 32'h40,       0, 1, 2, 1, 1};
        tbl[8]  = '{0, 32'h0,        0, 32'h0,   1, 1, 32'h380, 1,  1, 32'h380, 1, 32'h60,       1, 0, 3, 2, 0};
        tbl[9]  = '{1, 32'h64,       0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h380, 0, 32'h60,       1, 0, 3, 2, 1};
        tbl[10] = '{1, 32'hFFFFFFFC, 1, 32'h10,  0, 0, 32'h0,   1,  0, 32'h380, 0, 32'h60,       1, 1, 3, 2, 1};
        tbl[11] = '{1, 32'h70,       1, 32'h90,  1, 0, 32'h0,   1,  1, 32'h0,   1, 32'hFFFFFFFC, 0, 0, 4, 3, 0};
        tbl[12] = '{0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h0,   0, 32'hFFFFFFFC, 0, 0, 4, 3, 1};
        tbl[13] = '{1, 32'h80,       0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h0,   0, 32'hFFFFFFFC, 0, 1, 4, 3, 1};
        tbl[14] = '{1, 32'h84,       1, 32'hA0,  1, 0, 32'h0,   1,  0, 32'h0,   1, 32'h80,       0, 1, 5, 3, 1};
        tbl[15] = '{0, 32'h0,        0, 32'h0,   1, 1, 32'hA0,  1,  0, 32'h0,   1, 32'h84,       1, 0, 6, 3, 1};
        tbl[16] = '{0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h0,   0, 32'h84,       1, 0, 6, 3, 1};

        // reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_flush", 64'(flush), 64'd0);
        chk("reset_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("reset_upd_valid", 64'(upd_valid), 64'd0);
        chk("reset_upd_pc", 64'(upd_pc), 64'd0);
        chk("reset_counters", 64'({branch_cnt, mispred_cnt}), 64'd0);
        chk("reset_err", 64'(err_underflow), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].pv, tbl[i].ppc, tbl[i].pt, tbl[i].ptg,
                  tbl[i].rv, tbl[i].rt, tbl[i].rtg, tbl[i].ur);
            step();
            chk($sformatf("row%0d_flush", i), 64'(flush), 64'(tbl[i].e_fl));
            chk($sformatf("row%0d_redirect", i), 64'(redirect_pc), 64'(tbl[i].e_rd));
            chk($sformatf("row%0d_upd_valid", i), 64'(upd_valid), 64'(tbl[i].e_uv));
            chk($sformatf("row%0d_upd_pc", i), 64'(upd_pc), 64'(tbl[i].e_upc));
            chk($sformatf("row%0d_upd_taken", i), 64'(upd_taken), 64'(tbl[i].e_ut));
            chk($sformatf("row%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
            chk($sformatf("row%0d_branch_cnt", i), 64'(branch_cnt), 64'(tbl[i].e_b));
            chk($sformatf("row%0d_mispred_cnt", i), 64'(mispred_cnt), 64'(tbl[i].e_m));
            chk($sformatf("row%0d_pred_ready", i), 64'(pred_ready), 64'(tbl[i].e_pr));
            $display("row %0d: flush=%0b redirect=%0h upd=%0b/%0h/%0b occ=%0d br=%0d mp=%0d",
                     i, flush, redirect_pc, upd_valid, upd_pc, upd_taken, occupancy,
                     branch_cnt, mispred_cnt);
        end

        // full queue and update backpressure
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h200 + 32'(4 * i), 0, 0, 0, 0, 0, 1);
            step();
        end
        chk("full_occupancy", 64'(occupancy), 64'(DEPTH));
        chk("full_pred_ready", 64'(pred_ready), 64'd0);
        drive(1, 32'h210, 0, 0, 1, 0, 0, 0);
        step();
        chk("full_pop_no_bypass_occ", 64'(occupancy), 64'd3);
        chk("full_pop_upd_pc", 64'(upd_pc), 64'h200);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("stall_res_ready", 64'(res_ready), 64'd0);
        step();
        chk("stall_upd_valid", 64'(upd_valid), 64'd1);
        chk("stall_upd_pc_hold", 64'(upd_pc), 64'h200);
        chk("stall_occupancy", 64'(occupancy), 64'd3);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        #1;
        chk("release_res_ready", 64'(res_ready), 64'd1);
        step();
        chk("reload_upd_valid", 64'(upd_valid), 64'd1);
        chk("reload_upd_pc", 64'(upd_pc), 64'h204);
        chk("reload_occupancy", 64'(occupancy), 64'd2);
        step();
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        chk("drain_branch_cnt", 64'(branch_cnt), 64'd10);
        $display("backpressure sequence done: occ=%0d br=%0d", occupancy, branch_cnt);

        // underflow, including a push into the empty queue in the same cycle
        drive(0, 0, 0, 0, 1, 1, 32'h123, 1);
        step();
        chk("uflow_err", 64'(err_underflow), 64'd1);
        chk("uflow_branch_cnt", 64'(branch_cnt), 64'd10);
        chk("uflow_upd_valid", 64'(upd_valid), 64'd0);
        drive(1, 32'h300, 0, 0, 1, 0, 0, 1);
        step();
        chk("uflow_push_occ", 64'(occupancy), 64'd1);
        chk("uflow_push_branch_cnt", 64'(branch_cnt), 64'd10);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        step();
        chk("uflow_after_upd_pc", 64'(upd_pc), 64'h300);
        chk("uflow_after_branch_cnt", 64'(branch_cnt), 64'd11);
        $display("underflow sequence done: err=%0b br=%0d", err_underflow, branch_cnt);

        // asynchronous reset with 3 entries queued and an update pending
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h400 + 32'(4 * i), 0, 0, 0, 0, 0, 1);
            step();
        end
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        step();
        chk("prereset_occ", 64'(occupancy), 64'd3);
        chk("prereset_upd_valid", 64'(upd_valid), 64'd1);
        async_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        $display("mid-run reset done: occ=%0d upd_valid=%0b", occupancy, upd_valid);

        // counter saturation
        drive(1, 32'h500, 0, 0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < CMAX + 1; i++) begin
            drive(1, 32'h500, 0, 0, 1, 0, 0, 1);
            step();
        end
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        step();
        chk("sat_branch_cnt", 64'(branch_cnt), 64'(CMAX));
        for (int i = 0; i < CMAX + 2; i++) begin
            drive(1, 32'h600, 1, 32'h700, 0, 0, 0, 1);
            step();
            drive(0, 0, 0, 0, 1, 0, 0, 1);
            step();
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            step();
        end
        chk("sat_mispred_cnt", 64'(mispred_cnt), 64'(CMAX));
        chk("sat_branch_cnt_hold", 64'(branch_cnt), 64'(CMAX));
        $display("saturation done: br=%0d mp=%0d", branch_cnt, mispred_cnt);

        // randomized traffic against the model
        async_reset();
        for (int n = 0; n < 4000; n++) begin
            logic pv, pt, rv, rt, ur;
            logic [PC_W-1:0] ppc, ptg, rtg;
            pv  = ($urandom_range(0, 99) < 60);
            ppc = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            pt  = 1'($urandom_range(0, 1));
            ptg = ($urandom_range(0, 1) != 0) ? 32'h2000 : 32'h3000;
            rv  = ($urandom_range(0, 99) < 45);
            ur  = ($urandom_range(0, 99) < 70);
            if (mq.size() > 0 && $urandom_range(0, 99) < 80) begin
                rt  = mq[0].taken;
                rtg = ($urandom_range(0, 99) < 85) ? mq[0].tgt : 32'h3800;
            end else begin
                rt  = 1'($urandom_range(0, 1));
                rtg = ($urandom_range(0, 1) != 0) ? 32'h2000 : 32'h3000;
            end
            drive(pv, ppc, pt, ptg, rv, rt, rtg, ur);
            step();
            if ($urandom_range(0, 499) == 0) async_reset();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        $display("random phase done: br=%0d mp=%0d", branch_cnt, mispred_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
